pipeline_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage in-order core. It drives the `pause`/`bubble` pair of each pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold. It resolves data-memory wait states, taken-branch flushes, load-use hazards and instruction-fetch stalls. A small FSM tracks outstanding data-memory accesses and latches a sticky timeout error.

---
 rtl/pipeline_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: pause/bubble per pipeline register, PC hold, dmem timeout FSM.
// Optional EX/MEM forwarding hazard model selected by PIPE_FWD_EN.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic       ex_branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_req,
    input  logic       dmem_ack,
    output logic       pc_pause,
    output logic       if_id_pause,
    output logic       if_id_bubble,
    output logic       id_ex_pause,
    output logic       id_ex_bubble,
    output logic       ex_mem_pause,
    output logic       ex_mem_bubble,
    output logic       mem_wb_pause,
    output logic       mem_wb_bubble,
    output logic       mem_timeout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_stall;
    logic             data_hazard;

    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    assign mem_stall = dmem_req & ~dmem_ack;

    logic ex_hit;
    assign ex_hit = (id_rs1_used & reg_match(id_rs1, ex_rd))
                  | (id_rs2_used & reg_match(id_rs2, ex_rd));

`ifdef PIPE_FWD_EN
    logic unused_mem;
    assign unused_mem  = ^{mem_rd, mem_reg_write};
    assign data_hazard = ex_mem_read & ex_reg_write & ex_hit;
`else
    logic mem_hit;
    assign mem_hit = (id_rs1_used & reg_match(id_rs1, mem_rd))
                   | (id_rs2_used & reg_match(id_rs2, mem_rd));
    // Write-first regfile: a producer in WB is already visible to ID.
    assign data_hazard = (ex_reg_write & ex_hit) | (mem_reg_write & mem_hit);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating count of consecutive un-acked request cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (mem_stall) begin
            if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack | ~dmem_req) begin
                    state_d = RUN;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        pc_pause      = 1'b0;
        if_id_pause   = 1'b0;
        if_id_bubble  = 1'b0;
        id_ex_pause   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_pause  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_pause  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!reset_n) begin
            if_id_bubble  = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (state_q == ERROR) begin
            pc_pause     = 1'b1;
            if_id_pause  = 1'b1;
            id_ex_pause  = 1'b1;
            ex_mem_pause = 1'b1;
            mem_wb_pause = 1'b1;
        end else if (mem_stall) begin
            pc_pause      = 1'b1;
            if_id_pause   = 1'b1;
            id_ex_pause   = 1'b1;
            ex_mem_pause  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_bubble = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (data_hazard) begin
            pc_pause     = 1'b1;
            if_id_pause  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (!imem_ready) begin
            pc_pause     = 1'b1;
            if_id_bubble = 1'b1;
        end
    end

    assign mem_timeout = (state_q == ERROR);
    assign state       = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT = 8.
// Hazard expectations follow PIPE_FWD_EN when it is defined.
module tb_pipeline_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_rs1_used, id_rs2_used;
    logic       ex_reg_write, ex_mem_read, mem_reg_write;
    logic       ex_branch_taken, imem_ready, dmem_req, dmem_ack;
    logic       pc_pause, if_id_pause, if_id_bubble;
    logic       id_ex_pause, id_ex_bubble;
    logic       ex_mem_pause, ex_mem_bubble;
    logic       mem_wb_pause, mem_wb_bubble;
    logic       mem_timeout;
    logic [1:0] state;
    logic [8:0] ctl;

    int total = 0;
    int bad   = 0;

    // {pc, if_id p/b, id_ex p/b, ex_mem p/b, mem_wb p/b}
    localparam logic [8:0] IDLE  = 9'b000000000;
    localparam logic [8:0] RST   = 9'b001010101;
    localparam logic [8:0] FRZ   = 9'b110101010;
    localparam logic [8:0] MSTL  = 9'b110101001;
    localparam logic [8:0] BRN   = 9'b001010000;
    localparam logic [8:0] HAZ   = 9'b110010000;
    localparam logic [8:0] FTCH  = 9'b101000000;

`ifdef PIPE_FWD_EN
    localparam logic [8:0] ALU_HZ = IDLE;
`else
    localparam logic [8:0] ALU_HZ = HAZ;
`endif

    pipeline_ctrl #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write),
        .ex_branch_taken(ex_branch_taken),
        .imem_ready(imem_ready),
        .dmem_req(dmem_req),
        .dmem_ack(dmem_ack),
        .pc_pause(pc_pause),
        .if_id_pause(if_id_pause),
        .if_id_bubble(if_id_bubble),
        .id_ex_pause(id_ex_pause),
        .id_ex_bubble(id_ex_bubble),
        .ex_mem_pause(ex_mem_pause),
        .ex_mem_bubble(ex_mem_bubble),
        .mem_wb_pause(mem_wb_pause),
        .mem_wb_bubble(mem_wb_bubble),
        .mem_timeout(mem_timeout),
        .state(state)
    );

    assign ctl = {pc_pause, if_id_pause, if_id_bubble,
                  id_ex_pause, id_ex_bubble,
                  ex_mem_pause, ex_mem_bubble,
                  mem_wb_pause, mem_wb_bubble};

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] ec,
                       input logic [1:0] es);
        #1;
        total++;
        assert (ctl === ec) else begin
            bad++;
            $error("FAIL %s ctl got=%b exp=%b", tag, ctl, ec);
        end
        total++;
        assert (state === es) else begin
            bad++;
            $error("FAIL %s state got=%0d exp=%0d", tag, state, es);
        end
        total++;
        assert (mem_timeout === (es == 2'd2)) else begin
            bad++;
            $error("FAIL %s mem_timeout got=%b exp=%b", tag,
                   mem_timeout, (es == 2'd2));
        end
    endtask

    task automatic clear();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0;
        ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0;
        ex_branch_taken = 0; imem_ready = 1;
        dmem_req = 0; dmem_ack = 0;
    endtask

    initial begin
        clear();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_hold", RST, 2'd0);
            step();
        end
        reset_n = 1'b1;
        chk("reset_release", IDLE, 2'd0);
        step();

        // load-use on rs1
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
        id_rs1 = 5; id_rs1_used = 1;
        chk("load_use_rs1", HAZ, 2'd0);
        step();
        // bubble in EX, load now in MEM
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
        mem_rd = 5; mem_reg_write = 1;
        chk("load_in_mem", ALU_HZ, 2'd0);
        step();
        clear();

        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0;
        id_rs1 = 0; id_rs1_used = 1;
        chk("x0_no_hazard", IDLE, 2'd0);
        step();
        ex_rd = 5; id_rs1 = 5; id_rs1_used = 0;
        chk("rs1_unused", IDLE, 2'd0);
        step();
        id_rs2 = 5; id_rs2_used = 1;
        chk("load_use_rs2", HAZ, 2'd0);
        step();
        clear();

        ex_reg_write = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
        chk("alu_ex_dep", ALU_HZ, 2'd0);
        step();
        clear();
        mem_reg_write = 1; mem_rd = 3; id_rs2 = 3; id_rs2_used = 1;
        chk("alu_mem_dep", ALU_HZ, 2'd0);
        step();
        clear();

        imem_ready = 0;
        chk("fetch_stall", FTCH, 2'd0);
        step();
        ex_branch_taken = 1;
        chk("branch_over_fetch", BRN, 2'd0);
        step();
        clear();
        ex_branch_taken = 1;
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 4;
        id_rs1 = 4; id_rs1_used = 1;
        chk("branch_over_hazard", BRN, 2'd0);
        step();
        clear();

        // memory wait, ack on 5th cycle
        dmem_req = 1;
        for (int i = 0; i < 4; i++) begin
            chk("mem_wait", MSTL, (i == 0) ? 2'd0 : 2'd1);
            step();
        end
        dmem_ack = 1;
        chk("mem_ack", IDLE, 2'd1);
        step();
        clear();
        chk("mem_back_run", IDLE, 2'd0);
        step();

        // branch held during memory stall
        dmem_req = 1; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            chk("branch_in_stall", MSTL, (i == 0) ? 2'd0 : 2'd1);
            step();
        end
        dmem_ack = 1;
        chk("branch_after_ack", BRN, 2'd1);
        step();
        clear();
        chk("branch_done", IDLE, 2'd0);
        step();

        // same-cycle ack
        dmem_req = 1; dmem_ack = 1;
        chk("same_cycle_ack", IDLE, 2'd0);
        step();
        clear();
        chk("same_cycle_after", IDLE, 2'd0);
        step();

        // request withdrawn while waiting
        dmem_req = 1;
        chk("withdraw_req", MSTL, 2'd0);
        step();
        dmem_req = 0;
        chk("withdraw_drop", IDLE, 2'd1);
        step();
        chk("withdraw_run", IDLE, 2'd0);
        step();

        // ack on the timeout boundary cycle
        dmem_req = 1;
        for (int i = 0; i < 7; i++) begin
            chk("bound_wait", MSTL, (i == 0) ? 2'd0 : 2'd1);
            step();
        end
        dmem_ack = 1;
        chk("bound_ack", IDLE, 2'd1);
        step();
        clear();
        chk("bound_run", IDLE, 2'd0);
        step();

        // reset mid-stall clears counter
        dmem_req = 1;
        for (int i = 0; i < 5; i++) begin
            chk("pre_reset_wait", MSTL, (i == 0) ? 2'd0 : 2'd1);
            step();
        end
        #2;
        reset_n = 1'b0;
        chk("reset_mid_stall", RST, 2'd0);
        dmem_req = 0;
        step();
        reset_n = 1'b1;
        chk("reset_mid_release", IDLE, 2'd0);
        step();

        // timeout: 8 un-acked cycles
        dmem_req = 1;
        for (int i = 0; i < 8; i++) begin
            chk("tmo_wait", MSTL, (i == 0) ? 2'd0 : 2'd1);
            step();
        end
        chk("tmo_error", FRZ, 2'd2);
        step();
        dmem_ack = 1; ex_branch_taken = 1;
        chk("tmo_sticky_ack", FRZ, 2'd2);
        step();
        clear();
        chk("tmo_sticky_idle", FRZ, 2'd2);
        step();

        #2;
        reset_n = 1'b0;
        chk("tmo_reset", RST, 2'd0);
        step();
        reset_n = 1'b1;
        chk("tmo_reset_release", IDLE, 2'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
